axis_pack_64_512: RTL
=====================

Name: axis_pack_64_512

Overview:
- Packs 64-bit FFT output samples (16-bit re/im pairs etc.) into 512-bit host-stream beats on the send path, after xfft_0 and ahead of the 512-bit host source.
- It is the write-side counterpart of the 512→64 unpacker on the receive path.
- Handles short frames: flushes a partial beat on tlast with correct tkeep.
- Tracks a per-beat tid and counts completed frames.

Parameters:
- IN_W, 64, input data width in bits; multiple of 8.
- OUT_W, 512, output data width in bits; must equal IN_W*RATIO with RATIO a power of 2, at least 2.
- ID_W, 16, tid width.
- CNT_W, 32, width of the frame counter.
- RATIO, OUT_W/IN_W = 8. Derived, not overridable.

Ports:
- aclk, in, 1: clock. All logic is on the rising edge.
- aresetn, in, 1: asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronised to aclk.
- s_axis_tvalid, in, 1: input valid.
- s_axis_tready, out, 1: input ready.
- s_axis_tdata, in, IN_W: input word.
- s_axis_tlast, in, 1: last word of frame.
- s_axis_tid, in, ID_W: stream id.
- m_axis_tvalid, out, 1: output valid.
- m_axis_tready, in, 1: output ready.
- m_axis_tdata, out, OUT_W: packed beat.
- m_axis_tkeep, out, OUT_W/8: byte enables.
- m_axis_tlast, out, 1: last beat of frame.
- m_axis_tid, out, ID_W: beat id.
- frames_out, out, CNT_W: count of accepted output beats with tlast=1.
- err_tid, out, 1: sticky flag. Set when tid changes inside a beat.

Behaviour:
- Reset values: lane counter=0, accumulator=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, m_axis_tid=0, frames_out=0, err_tid=0.
- Reset mid-operation discards any partial beat and any pending output beat. No beat is emitted for it.
- Storage is two stages: an accumulator (RATIO lanes plus a lane counter 0..RATIO-1) and one output register.
- s_axis_tready = !m_axis_tvalid || m_axis_tready. This is combinational from m_axis_tready and is independent of s_axis_tvalid.
- Accepted word (s_axis_tvalid && s_axis_tready):
  - Written to accumulator lane L, bits [IN_W*L +: IN_W]. Lane 0 is the LSBs, so the first sample sits at the low bits.
- tid handling:
  - On L=0, the word's tid is latched as the beat tid.
  - On L>0 with a differing tid, err_tid sets and stays set until reset. The beat keeps the lane-0 tid.
- A word is completing if L==RATIO-1 or s_axis_tlast=1.
- Completing word:
  - The next cycle, the output register loads data, tid and tlast (equal to the input tlast).
  - tkeep = low (L+1)*IN_W/8 bits set, the rest 0.
  - Unfilled lanes output as zero.
  - m_axis_tvalid=1.
  - Accumulator and lane counter clear the same edge.
- Non-completing word: L increments.
- Latency: the output beat is valid 1 cycle after its completing word is accepted.
- Throughput: 1 input word/cycle sustained while m_axis_tready=1. A new beat may load in the same cycle the previous one is accepted.
- Output handshake (AXI-Stream): once m_axis_tvalid=1, data, tkeep, tlast and tid hold stable until m_axis_tready=1. tvalid never drops without acceptance.
- Backpressure: while m_axis_tvalid && !m_axis_tready, s_axis_tready=0. No input is lost and the accumulator is frozen.
- frames_out increments on each accepted output beat with tlast=1. It wraps modulo 2^CNT_W.
- A full frame of RATIO*k words yields k beats, all with tkeep all-ones and tlast on beat k.
- A one-word frame (first word tlast=1) yields one beat with tkeep=0x...00FF and tlast=1.
- An idle input with a partial accumulator holds indefinitely. There is no timeout flush.

Test Plan:
- Stream words 0x0..0xF (16 words), tlast on word 15, m_axis_tready=1:
  - Beat 0 lane L = L, beat 1 lane L = 8+L.
  - tkeep = all 64 bits set on both beats; tlast only on beat 1.
  - frames_out = 1.
  - Each beat appears 1 cycle after its 8th word.
- 11-word frame, tlast on word 10:
  - Beat 1 has lanes 0–2 = words 8–10 and lanes 3–7 = 0.
  - tkeep = 0x0000_0000_00FF_FFFF, tlast=1.
- Hold m_axis_tready=0 for 20 cycles with continuous input:
  - s_axis_tready drops after the first completed beat.
  - The beat holds stable; on release all 16 words arrive intact and in order.
- tid=3 on lanes 0–3 and tid=5 on lanes 4–7:
  - m_axis_tid=3 and err_tid=1, remaining 1 until reset.
- Assert aresetn=0 after 5 words of a beat:
  - All outputs go to reset values asynchronously.
  - The next 8-word frame emits exactly one beat containing only new data.
- Random m_axis_tready (50%) over 1000 random frames of 1–64 words:
  - Scoreboard matches all data and tkeep.
  - frames_out = 1000.
  - No AXI stability violations.

Source files
------------

// File: rtl/axis_pack_64_512_if.sv
// Stream bundle for the 64->512 packer: narrow input stream (s_axis_*) and wide output stream (m_axis_*).
// The slave modport is the packer's view; the master modport is the view of whatever surrounds it.
interface axis_pack_64_512_if #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 512,
  parameter int ID_W  = 16
);
  // Handshake on both streams: a transfer happens on a rising clock edge where tvalid and
  // tready are both 1; a raised tvalid and its payload stay put until that transfer happens.
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic [IN_W-1:0]    s_axis_tdata;
  logic               s_axis_tlast;
  logic [ID_W-1:0]    s_axis_tid;

  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic [OUT_W-1:0]   m_axis_tdata;
  logic [OUT_W/8-1:0] m_axis_tkeep;
  logic               m_axis_tlast;
  logic [ID_W-1:0]    m_axis_tid;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tid, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tid, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid
  );
endinterface

// File: rtl/axis_pack_64_512.sv
// Packs IN_W-bit stream words into OUT_W-bit beats (first word in the low lane), flushing a
// partial beat with trimmed tkeep on tlast; tracks the beat tid and counts emitted frames.
module axis_pack_64_512 #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 512,
  parameter int ID_W  = 16,
  parameter int CNT_W = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axis_pack_64_512_if.slave    axis,
  output logic [CNT_W-1:0]     frames_out,
  output logic                 err_tid
);
  localparam int RATIO  = OUT_W / IN_W;
  localparam int LW     = $clog2(RATIO);
  localparam int KEEP_W = OUT_W / 8;
  localparam int LANE_B = IN_W / 8;
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  // Reset asserts asynchronously but releases only on a clock edge.
  logic rst_meta;
  logic rst_n;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  logic [OUT_W-1:0]  acc;
  logic [LW-1:0]     lane;
  logic [ID_W-1:0]   beat_tid;

  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic [KEEP_W-1:0] out_keep;
  logic              out_last;
  logic [ID_W-1:0]   out_tid;

  logic              s_ready;
  logic              accept;
  logic              completing;
  logic [OUT_W-1:0]  beat_data;
  logic [KEEP_W-1:0] beat_keep;
  logic [ID_W-1:0]   beat_tid_n;

  always_comb begin
    s_ready    = !out_valid || axis.m_axis_tready;
    accept     = axis.s_axis_tvalid && s_ready;
    completing = accept && ((lane == LAST_LANE) || axis.s_axis_tlast);
    // Lanes above the current one are still zero, so a flushed beat carries zeros there.
    beat_data  = acc;
    beat_data[lane*IN_W +: IN_W] = axis.s_axis_tdata;
    beat_keep  = '0;
    for (int i = 0; i < RATIO; i++) begin
      beat_keep[i*LANE_B +: LANE_B] = (i <= int'(lane)) ? {LANE_B{1'b1}} : {LANE_B{1'b0}};
    end
    beat_tid_n = (lane == '0) ? axis.s_axis_tid : beat_tid;
  end

  // Accumulator stage.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      lane     <= '0;
      beat_tid <= '0;
      err_tid  <= 1'b0;
    end else if (accept) begin
      beat_tid <= beat_tid_n;
      if (lane != '0 && axis.s_axis_tid != beat_tid) begin
        err_tid <= 1'b1;
      end
      if (completing) begin
        acc  <= '0;
        lane <= '0;
      end else begin
        acc  <= beat_data;
        lane <= lane + LW'(1);
      end
    end
  end

  // Output register: reloads in the same cycle its current beat is taken.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_tid   <= '0;
    end else if (completing) begin
      out_valid <= 1'b1;
      out_data  <= beat_data;
      out_keep  <= beat_keep;
      out_last  <= axis.s_axis_tlast;
      out_tid   <= beat_tid_n;
    end else if (axis.m_axis_tready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      frames_out <= '0;
    end else if (out_valid && axis.m_axis_tready && out_last) begin
      frames_out <= frames_out + CNT_W'(1);
    end
  end

  assign axis.s_axis_tready = s_ready;
  assign axis.m_axis_tvalid = out_valid;
  assign axis.m_axis_tdata  = out_data;
  assign axis.m_axis_tkeep  = out_keep;
  assign axis.m_axis_tlast  = out_last;
  assign axis.m_axis_tid    = out_tid;
endmodule
